// File: rtl/lfsr_word_gen_if.sv
// lfsr_word_gen_if: valid/ready word channel for the LFSR word source.
// The master drives valid/data; the slave drives ready.
interface lfsr_word_gen_if #(
  parameter int OUT_WIDTH = 8
);
  logic                 valid;
  logic                 ready;
  logic [OUT_WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/lfsr_word_gen.sv
// lfsr_word_gen: Fibonacci/Galois LFSR packing bits into valid/ready words.
// Define LFSR_PERIOD_MON_EN to add the step_count/period_hit monitor.
module lfsr_word_gen #(
  parameter int          NUM_BITS  = 5,
  parameter logic [31:0] TAPS      = 32'h0000_001B,
  parameter logic [31:0] SEED      = 32'd1,
  parameter bit          MODE      = 1'b0,
  parameter int          OUT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                seed_valid,
  input  logic [NUM_BITS-1:0] seed_data,
  lfsr_word_gen_if.master     out,
  output logic                lockup
`ifdef LFSR_PERIOD_MON_EN
  ,
  output logic [31:0]         step_count,
  output logic                period_hit
`endif
);

  localparam int CW = $clog2(OUT_WIDTH + 1);
  localparam logic [NUM_BITS-1:0] TAP_M =
    TAPS[NUM_BITS-1:0];
  localparam logic [NUM_BITS-1:0] SEED_M =
    SEED[NUM_BITS-1:0];
  localparam logic [CW-1:0] LAST = CW'(OUT_WIDTH - 1);

  typedef enum logic {
    FILL  = 1'b0,
    VALID = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_BITS-1:0]    sr_q, sr_d;
  logic [OUT_WIDTH-1:0]   word_q, word_d;
  logic [OUT_WIDTH-1:0]   data_q, data_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   lock_q, lock_d;
  logic                   step;

  logic                   bit_o;
  logic                   fb;
  logic                   sr_zero;
  logic [NUM_BITS-1:0]    step_sr;
  logic [OUT_WIDTH-1:0]   word_sh;

  always_comb begin
    bit_o   = sr_q[NUM_BITS-1];
    fb      = ^(sr_q & TAP_M);
    sr_zero = (sr_q == '0);
    if (MODE)
      step_sr = {sr_q[NUM_BITS-2:0], 1'b0}
              ^ (bit_o ? TAP_M : '0);
    else
      step_sr = {sr_q[NUM_BITS-2:0], fb};
    word_sh = OUT_WIDTH'({word_q, bit_o});
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    word_d  = word_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    lock_d  = 1'b0;
    step    = 1'b0;
    if (seed_valid) begin
      sr_d    = (seed_data == '0) ? SEED_M : seed_data;
      lock_d  = (seed_data == '0);
      word_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = FILL;
    end else if (enable) begin
      unique case (state_q)
        FILL: begin
          step   = 1'b1;
          // a zero register can never recover by shifting
          sr_d   = sr_zero ? SEED_M : step_sr;
          lock_d = sr_zero;
          word_d = word_sh;
          if (cnt_q == LAST) begin
            data_d  = word_sh;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = VALID;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        VALID: begin
          if (out.ready) begin
            valid_d = 1'b0;
            state_d = FILL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      sr_q    <= SEED_M;
      word_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
    end
  end

  assign out.valid = valid_q;
  assign out.data  = data_q;
  assign lockup    = lock_q;

`ifdef LFSR_PERIOD_MON_EN
  logic [NUM_BITS-1:0] load_q;
  logic [31:0]         steps_q;
  logic                hit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_q  <= SEED_M;
      steps_q <= '0;
      hit_q   <= 1'b0;
    end else if (seed_valid) begin
      load_q  <= sr_d;
      steps_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= step && (sr_d == load_q);
      if (step && (steps_q != 32'hFFFF_FFFF))
        steps_q <= steps_q + 32'd1;
    end
  end

  assign step_count = steps_q;
  assign period_hit = hit_q;
`endif

endmodule
